// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, one held instruction for decode.
// Optional macro FETCH_ADDR_CHECK_EN turns misaligned fetch targets into fetch_adel faults.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic        fetch_adel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_inst_req;
    logic [31:0] r_inst_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst_pc;
    logic [31:0] r_inst;
    logic        r_fetch_adel;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;
    logic [31:0] r_redir;

    state_t      w_nxt_state;
    logic        w_nxt_inst_req;
    logic [31:0] w_nxt_inst_addr;
    logic        w_nxt_inst_valid;
    logic [31:0] w_nxt_inst_pc;
    logic [31:0] w_nxt_inst;
    logic        w_nxt_fetch_adel;
    logic        w_nxt_br_pend;
    logic [31:0] w_nxt_br_tgt;
    logic [31:0] w_nxt_redir;

    logic        w_launch;
    logic [31:0] w_launch_addr;
    logic [31:0] w_seq_addr;
    logic        w_misaligned;

    // Sequential successor when the held instruction is consumed
    always_comb begin
        if (branch_flag)
            w_seq_addr = branch_addr;
        else if (r_br_pend)
            w_seq_addr = r_br_tgt;
        else
            w_seq_addr = r_inst_pc + 32'd4;
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_inst_req   = r_inst_req;
        w_nxt_inst_addr  = r_inst_addr;
        w_nxt_inst_valid = r_inst_valid;
        w_nxt_inst_pc    = r_inst_pc;
        w_nxt_inst       = r_inst;
        w_nxt_fetch_adel = r_fetch_adel;
        w_nxt_br_pend    = r_br_pend;
        w_nxt_br_tgt     = r_br_tgt;
        w_nxt_redir      = r_redir;
        w_launch         = 1'b0;
        w_launch_addr    = r_inst_addr;
        w_misaligned     = 1'b0;

        case (r_state)
            IDLE: begin
                w_launch      = 1'b1;
                w_launch_addr = flush ? flush_pc : RESET_VECTOR;
                w_nxt_br_pend = 1'b0;
            end
            FETCH: begin
                if (flush) begin
                    w_nxt_br_pend = 1'b0;
                    if (inst_ack) begin
                        w_launch      = 1'b1;
                        w_launch_addr = flush_pc;
                    end else begin
                        // Bus transaction cannot be cancelled; wait it out in DRAIN
                        w_nxt_state = DRAIN;
                        w_nxt_redir = flush_pc;
                    end
                end else begin
                    if (branch_flag) begin
                        w_nxt_br_pend = 1'b1;
                        w_nxt_br_tgt  = branch_addr;
                    end
                    if (inst_ack) begin
                        w_nxt_state      = OUT;
                        w_nxt_inst_req   = 1'b0;
                        w_nxt_inst_valid = 1'b1;
                        w_nxt_inst       = inst_rdata;
                        w_nxt_inst_pc    = r_inst_addr;
                        w_nxt_fetch_adel = 1'b0;
                    end
                end
            end
            OUT: begin
                if (flush) begin
                    w_nxt_br_pend = 1'b0;
                    w_launch      = 1'b1;
                    w_launch_addr = flush_pc;
                end else if (stall_if) begin
                    if (branch_flag) begin
                        w_nxt_br_pend = 1'b1;
                        w_nxt_br_tgt  = branch_addr;
                    end
                end else begin
                    w_nxt_br_pend = 1'b0;
                    w_launch      = 1'b1;
                    w_launch_addr = w_seq_addr;
                end
            end
            DRAIN: begin
                if (flush)
                    w_nxt_redir = flush_pc;
                if (inst_ack) begin
                    w_launch      = 1'b1;
                    w_launch_addr = flush ? flush_pc : r_redir;
                end
            end
            default: begin
                w_nxt_state    = IDLE;
                w_nxt_inst_req = 1'b0;
            end
        endcase

`ifdef FETCH_ADDR_CHECK_EN
        w_misaligned = (w_launch_addr[1:0] != 2'b00);
`else
        w_misaligned = 1'b0;
`endif

        // Start a new fetch, or fault it straight into OUT when misaligned
        if (w_launch) begin
            w_nxt_inst_addr = w_launch_addr;
            if (w_misaligned) begin
                w_nxt_state      = OUT;
                w_nxt_inst_req   = 1'b0;
                w_nxt_inst_valid = 1'b1;
                w_nxt_inst       = 32'h0;
                w_nxt_inst_pc    = w_launch_addr;
                w_nxt_fetch_adel = 1'b1;
            end else begin
                w_nxt_state      = FETCH;
                w_nxt_inst_req   = 1'b1;
                w_nxt_inst_valid = 1'b0;
                w_nxt_fetch_adel = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_inst_req   <= 1'b0;
            r_inst_addr  <= RESET_VECTOR;
            r_inst_valid <= 1'b0;
            r_inst_pc    <= 32'h0;
            r_inst       <= 32'h0;
            r_fetch_adel <= 1'b0;
            r_br_pend    <= 1'b0;
            r_br_tgt     <= 32'h0;
            r_redir      <= 32'h0;
        end else begin
            r_state      <= w_nxt_state;
            r_inst_req   <= w_nxt_inst_req;
            r_inst_addr  <= w_nxt_inst_addr;
            r_inst_valid <= w_nxt_inst_valid;
            r_inst_pc    <= w_nxt_inst_pc;
            r_inst       <= w_nxt_inst;
            r_fetch_adel <= w_nxt_fetch_adel;
            r_br_pend    <= w_nxt_br_pend;
            r_br_tgt     <= w_nxt_br_tgt;
            r_redir      <= w_nxt_redir;
        end
    end

    assign inst_req   = r_inst_req;
    assign inst_addr  = r_inst_addr;
    assign inst_valid = r_inst_valid;
    assign inst_pc    = r_inst_pc;
    assign inst       = r_inst;
    assign fetch_adel = r_fetch_adel;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected requests/deliveries, a monitor checks them.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        fetch_adel;

    fetch_ctrl #(.RESET_VECTOR(32'hbfc00000)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if),
        .branch_flag(branch_flag), .branch_addr(branch_addr),
        .flush(flush), .flush_pc(flush_pc),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst),
        .fetch_adel(fetch_adel)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
        logic        adel;
    } dlv_t;

    logic [31:0] exp_req_q[$];
    dlv_t        exp_dlv_q[$];
    int          total = 0;
    int          bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: a new request is req rising or the address moving while req stays high
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    always @(negedge clk) begin
        if (inst_req && (!prev_req || inst_addr != prev_addr)) begin
            if (exp_req_q.size() == 0) begin
                chk("unexpected_req", inst_addr, 32'hffffffff);
            end else begin
                logic [31:0] e;
                e = exp_req_q.pop_front();
                chk("req_addr", inst_addr, e);
            end
        end
        if (inst_valid && (!prev_valid || inst_pc != prev_pc)) begin
            if (exp_dlv_q.size() == 0) begin
                chk("unexpected_dlv", inst_pc, 32'hffffffff);
            end else begin
                dlv_t d;
                d = exp_dlv_q.pop_front();
                chk("dlv_pc", inst_pc, d.pc);
                chk("dlv_inst", inst, d.w);
                chk("dlv_adel", {31'h0, fetch_adel}, {31'h0, d.adel});
            end
        end
        prev_req   = inst_req;
        prev_addr  = inst_addr;
        prev_valid = inst_valid;
        prev_pc    = inst_pc;
    end

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_req && n < 30);
        if (!inst_req) chk("req_timeout", {31'h0, inst_req}, 32'h1);
    endtask

    // Answer the current request after dly cycles; returns one tick after the DUT entered OUT
    task automatic serve(input logic [31:0] data, input int dly);
        wait_req();
        repeat (dly) begin
            @(posedge clk); #1;
        end
        inst_ack   = 1'b1;
        inst_rdata = data;
        @(posedge clk); #1;
        inst_ack   = 1'b0;
    endtask

    function automatic dlv_t mk(input logic [31:0] pc, input logic [31:0] w, input logic adel);
        dlv_t d;
        d.pc = pc; d.w = w; d.adel = adel;
        return d;
    endfunction

    initial begin
        rst = 1'b1; stall_if = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
        flush = 1'b0; flush_pc = 32'h0; inst_ack = 1'b0; inst_rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_addr", inst_addr, 32'hbfc00000);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_adel", {31'h0, fetch_adel}, 32'h0);

        // First fetch, then stall in OUT for four cycles
        exp_req_q.push_back(32'hbfc00000);
        exp_dlv_q.push_back(mk(32'hbfc00000, 32'h3c010001, 1'b0));
        exp_req_q.push_back(32'hbfc00004);
        rst = 1'b0;
        stall_if = 1'b1;
        serve(32'h3c010001, 1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_req", {31'h0, inst_req}, 32'h0);
            chk("stall_pc", inst_pc, 32'hbfc00000);
            chk("stall_inst", inst, 32'h3c010001);
            @(posedge clk); #1;
        end
        stall_if = 1'b0;

        // Branch during FETCH of bfc00004 is held until that word is consumed
        exp_dlv_q.push_back(mk(32'hbfc00004, 32'h24020002, 1'b0));
        exp_req_q.push_back(32'h80001000);
        wait_req();
        branch_flag = 1'b1; branch_addr = 32'h80001000;
        @(posedge clk); #1;
        branch_flag = 1'b0;
        inst_ack = 1'b1; inst_rdata = 32'h24020002;
        @(posedge clk); #1;
        inst_ack = 1'b0;

        // Flush mid-fetch; second flush in DRAIN replaces the redirect
        exp_req_q.push_back(32'hbfc00380);
        wait_req();
        flush = 1'b1; flush_pc = 32'hbfc00180;
        @(posedge clk); #1;
        chk("drain_req", {31'h0, inst_req}, 32'h1);
        chk("drain_addr", inst_addr, 32'h80001000);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        flush_pc = 32'hbfc00380;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("drain_addr2", inst_addr, 32'h80001000);
        @(posedge clk); #1;
        inst_ack = 1'b1; inst_rdata = 32'hdeadbeef;
        @(posedge clk); #1;
        inst_ack = 1'b0;

        // Branch while stalled becomes pending; pending target taken, then wrap at 2^32
        exp_dlv_q.push_back(mk(32'hbfc00380, 32'h8c220000, 1'b0));
        exp_req_q.push_back(32'hfffffffc);
        exp_dlv_q.push_back(mk(32'hfffffffc, 32'h11111111, 1'b0));
        exp_req_q.push_back(32'h00000000);
        exp_dlv_q.push_back(mk(32'h00000000, 32'h22222222, 1'b0));
        exp_req_q.push_back(32'h00000004);
        exp_req_q.push_back(32'h00000100);
        stall_if = 1'b1;
        serve(32'h8c220000, 0);
        branch_flag = 1'b1; branch_addr = 32'hfffffffc;
        @(posedge clk); #1;
        branch_flag = 1'b0;
        chk("pend_hold_pc", inst_pc, 32'hbfc00380);
        stall_if = 1'b0;
        serve(32'h11111111, 2);
        serve(32'h22222222, 0);

        // Flush coincident with ack: response discarded
        wait_req();
        flush = 1'b1; flush_pc = 32'h00000100;
        inst_ack = 1'b1; inst_rdata = 32'hbadc0ffe;
        @(posedge clk); #1;
        flush = 1'b0; inst_ack = 1'b0;

        // Reset mid-transaction, late ack while IDLE ignored
        exp_req_q.push_back(32'hbfc00000);
        exp_dlv_q.push_back(mk(32'hbfc00000, 32'h3c010001, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_req", {31'h0, inst_req}, 32'h0);
        chk("mrst_valid", {31'h0, inst_valid}, 32'h0);
        chk("mrst_addr", inst_addr, 32'hbfc00000);
        rst = 1'b0;
        inst_ack = 1'b1; inst_rdata = 32'h0badf00d;
        @(posedge clk); #1;
        inst_ack = 1'b0;
        serve(32'h3c010001, 0);

        // Branch on the consuming cycle to a misaligned target
`ifdef FETCH_ADDR_CHECK_EN
        exp_dlv_q.push_back(mk(32'h80001002, 32'h0, 1'b1));
`else
        exp_req_q.push_back(32'h80001002);
        exp_dlv_q.push_back(mk(32'h80001002, 32'h33333333, 1'b0));
`endif
        branch_flag = 1'b1; branch_addr = 32'h80001002;
        @(posedge clk); #1;
        branch_flag = 1'b0;
        stall_if = 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
        chk("adel_req", {31'h0, inst_req}, 32'h0);
        chk("adel_flag", {31'h0, fetch_adel}, 32'h1);
`else
        serve(32'h33333333, 0);
        chk("noadel_flag", {31'h0, fetch_adel}, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_empty", exp_req_q.size(), 32'h0);
        chk("dlv_q_empty", exp_dlv_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
